// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter between instruction fetch and data access.
// Data wins by default; a pending fetch is forced ahead after STARVE_MAX data grants.
module mem_arbiter #(
  parameter int STARVE_MAX = 4
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic        iwait,
  output logic [31:0] iload,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        dwait,
  output logic [31:0] dload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic        ram_ready
);

  localparam int CW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] SMAX = CW'(STARVE_MAX);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DSERV = 2'd1,
    ISERV = 2'd2
  } state_t;

  state_t          r_state;
  logic [CW-1:0]   r_starve_cnt;
  logic            r_ramREN;
  logic            r_ramWEN;
  logic [31:0]     r_ramaddr;
  logic [31:0]     r_ramstore;

  logic w_ireq;
  logic w_dreq;
  logic w_starved;
  logic w_grant_i;
  logic w_grant_d;

  assign w_ireq    = iREN;
  assign w_dreq    = dREN | dWEN;
  assign w_starved = w_ireq & (r_starve_cnt >= SMAX);
  assign w_grant_i = w_starved | (w_ireq & ~w_dreq);
  assign w_grant_d = ~w_starved & w_dreq;

  // Arbitration FSM; RAM outputs are latched at grant so requesters may change inputs mid-service.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state      <= IDLE;
      r_starve_cnt <= {CW{1'b0}};
      r_ramREN     <= 1'b0;
      r_ramWEN     <= 1'b0;
      r_ramaddr    <= 32'd0;
      r_ramstore   <= 32'd0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_grant_i) begin
            r_state      <= ISERV;
            r_ramREN     <= 1'b1;
            r_ramWEN     <= 1'b0;
            r_ramaddr    <= iaddr;
            r_ramstore   <= 32'd0;
            r_starve_cnt <= {CW{1'b0}};
          end else if (w_grant_d) begin
            r_state    <= DSERV;
            r_ramREN   <= ~dWEN;
            r_ramWEN   <= dWEN;
            r_ramaddr  <= daddr;
            r_ramstore <= dstore;
            if (!iREN) begin
              r_starve_cnt <= {CW{1'b0}};
            end else if (r_starve_cnt != SMAX) begin
              r_starve_cnt <= r_starve_cnt + CW'(1);
            end else begin
              r_starve_cnt <= r_starve_cnt;
            end
          end else if (!iREN) begin
            r_starve_cnt <= {CW{1'b0}};
          end else begin
            r_starve_cnt <= r_starve_cnt;
          end
        end
        DSERV, ISERV: begin
          if (ram_ready) begin
            r_state    <= IDLE;
            r_ramREN   <= 1'b0;
            r_ramWEN   <= 1'b0;
            r_ramaddr  <= 32'd0;
            r_ramstore <= 32'd0;
          end else begin
            r_state <= r_state;
          end
        end
        default: begin
          r_state    <= IDLE;
          r_ramREN   <= 1'b0;
          r_ramWEN   <= 1'b0;
          r_ramaddr  <= 32'd0;
          r_ramstore <= 32'd0;
        end
      endcase
    end
  end

  assign ramREN   = r_ramREN;
  assign ramWEN   = r_ramWEN;
  assign ramaddr  = r_ramaddr;
  assign ramstore = r_ramstore;

  // Wait drops only in the completing cycle of the requester's own service.
  assign iwait = w_ireq & ~((r_state == ISERV) & ram_ready);
  assign dwait = w_dreq & ~((r_state == DSERV) & ram_ready);
  assign iload = (r_state == ISERV) ? ramload : 32'd0;
  assign dload = (r_state == DSERV) ? ramload : 32'd0;

endmodule
